fetch_pcreg: RTL and testbench

Fetch-stage PC register and instruction-request engine. It sits directly downstream of the PC-select mux.
- Holds the current fetch PC and issues one SRAM-like instruction request at a time.
- Captures the returned word into a one-entry output buffer with a valid/ready handshake toward decode.
- On each accepted fetch, loads the next PC from the mux's pc_new.
- Kills in-flight requests on redirect.

---
 rtl/fetch_pcreg.sv | 133 +++++++++++++
 tb/tb_fetch_pcreg.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pcreg.sv
// Fetch-stage PC register and single-outstanding instruction request engine.
// Optional build macro: FETCH_ADDR_ALIGN_CHK_EN (misaligned PC raises out_exc instead of fetching).
module fetch_pcreg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] pc_new,
    input  logic              redirect,
    output logic [ADDR_W-1:0] pcplus4,
    output logic [ADDR_W-1:0] pc_f,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_exc
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              discard_q, discard_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              out_exc_q, out_exc_d;
    logic              buf_free_s;
    logic              misalign_s;

`ifdef FETCH_ADDR_ALIGN_CHK_EN
    assign misalign_s = (pc_q[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    assign buf_free_s = !out_valid_q || out_ready;
    assign inst_req   = resetn && (state_q == S_REQ) && buf_free_s && !misalign_s;
    assign inst_addr  = pc_q;
    assign pc_f       = pc_q;
    assign pcplus4    = pc_q + {{(ADDR_W-3){1'b0}}, 3'b100};
    assign out_valid  = out_valid_q;
    assign out_inst   = out_inst_q;
    assign out_pc     = out_pc_q;
    assign out_exc    = out_exc_q;

    // Next-state: request/response sequencing, output buffer, redirect override
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        discard_d   = discard_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_exc_d   = out_exc_q;
        case (state_q)
            S_REQ: begin
                if (inst_req && inst_addr_ok) begin
                    state_d   = S_WAIT;
                    req_pc_d  = pc_q;
                    discard_d = redirect;
                end else if (misalign_s && buf_free_s) begin
                    out_valid_d = 1'b1;
                    out_exc_d   = 1'b1;
                    out_pc_d    = pc_q;
                    out_inst_d  = 32'h0000_0000;
                end else begin
                    discard_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d   = S_REQ;
                    discard_d = 1'b0;
                    // A response arriving with a redirect belongs to the old path
                    if (!discard_q && !redirect) begin
                        out_inst_d  = inst_rdata;
                        out_pc_d    = req_pc_q;
                        out_valid_d = 1'b1;
                        out_exc_d   = 1'b0;
                        pc_d        = pc_new;
                    end else begin
                        out_inst_d = out_inst_q;
                    end
                end else begin
                    discard_d = discard_q | redirect;
                end
            end
            default: begin
                state_d   = S_REQ;
                discard_d = 1'b0;
            end
        endcase
        pc_d        = redirect ? pc_new : pc_d;
        out_valid_d = out_valid_d & ~redirect;
        out_exc_d   = out_exc_d & ~redirect;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= {ADDR_W{1'b0}};
            discard_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0000_0000;
            out_pc_q    <= {ADDR_W{1'b0}};
            out_exc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            discard_q   <= discard_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_exc_q   <= out_exc_d;
        end
    end

endmodule

// File: tb/tb_fetch_pcreg.sv
// Bench for fetch_pcreg: transaction-level model plus directed scenarios with literal checkpoints.
module tb_fetch_pcreg;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] MEM_K  = 32'h9BC8_0001;
    localparam logic [31:0] STALE  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] pc_new = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] pcplus4, pc_f, inst_addr, out_pc;
    logic        inst_req, out_valid, out_exc;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;

    fetch_pcreg dut (
        .clk(clk), .resetn(resetn), .pc_new(pc_new), .redirect(redirect),
        .pcplus4(pcplus4), .pc_f(pc_f), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: fetch PC, one outstanding request, one-entry buffer
    logic [31:0] m_pc, m_req_pc, m_binst, m_bpc;
    bit          m_busy, m_kill, m_bv, m_bexc;

    function automatic bit misal();
`ifdef FETCH_ADDR_ALIGN_CHK_EN
        return (m_pc[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_req();
        return resetn && !m_busy && (!m_bv || out_ready) && !misal();
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_req_pc = 32'h0; m_binst = 32'h0; m_bpc = 32'h0;
        m_busy = 1'b0; m_kill = 1'b0; m_bv = 1'b0; m_bexc = 1'b0;
    endtask

    task automatic model_step(input bit rd, input bit redir, input logic [31:0] pn,
                              input bit aok, input bit dok, input logic [31:0] rdat,
                              input bit req_exp);
        bit issue, resp, busy_old;
        busy_old = m_busy;
        issue = req_exp && aok;
        resp  = m_busy && dok;
        if (resp && !m_kill && !redir) begin
            m_binst = rdat; m_bpc = m_req_pc; m_bv = 1'b1; m_bexc = 1'b0; m_pc = pn;
        end else if (!m_busy && misal() && (!m_bv || rd) && !redir) begin
            m_binst = 32'h0; m_bpc = m_pc; m_bv = 1'b1; m_bexc = 1'b1;
        end else if (m_bv && rd) begin
            m_bv = 1'b0;
        end
        if (resp) begin m_busy = 1'b0; m_kill = 1'b0; end
        if (issue) begin m_busy = 1'b1; m_req_pc = m_pc; m_kill = redir; end
        if (redir) begin
            m_pc = pn; m_bv = 1'b0; m_bexc = 1'b0;
            if (busy_old && !resp) m_kill = 1'b1;
        end
    endtask

    // Memory: accepts every request, answers mem_lat cycles later
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = 32'h0;
    bit          mem_bad_cur = 1'b0;
    bit          mem_bad_next = 1'b0;

    task automatic cyc(input bit rd, input bit redir, input logic [31:0] tgt);
        bit s_req, s_aok, s_dok;
        logic [31:0] s_pn, s_rdat;
        @(negedge clk);
        out_ready = rd;
        redirect  = redir;
        pc_new    = redir ? tgt : m_pc + 32'd4;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_bad_cur ? STALE : (mem_addr ^ MEM_K);
            end
        end
        inst_addr_ok = 1'b1;
        #1;
        s_req = exp_req();
        if (inst_req && inst_addr_ok) begin
            mem_cnt = mem_lat; mem_addr = inst_addr;
            mem_bad_cur = mem_bad_next; mem_bad_next = 1'b0;
        end
        s_aok = inst_addr_ok; s_dok = inst_data_ok; s_pn = pc_new; s_rdat = inst_rdata;
        @(posedge clk);
        if (!resetn) model_reset();
        else model_step(rd, redir, s_pn, s_aok, s_dok, s_rdat, s_req);
    endtask

    // Per-cycle compare of every DUT output against the model
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("pc_f", pc_f, m_pc);
            chk("pcplus4", pcplus4, m_pc + 32'd4);
            chk("inst_addr", inst_addr, m_pc);
            chk("inst_req", {31'b0, inst_req}, {31'b0, exp_req()});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_bv});
            chk("out_exc", {31'b0, out_exc}, {31'b0, m_bexc});
            chk("out_inst", out_inst, m_binst);
            chk("out_pc", out_pc, m_bpc);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #1 resetn = 1'b0;
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("rst inst_req", {31'b0, inst_req}, 32'h0);
        chk("rst pc_f", pc_f, RST_PC);
        chk("rst out_valid", {31'b0, out_valid}, 32'h0);
        resetn = 1'b1;
        #1;
        chk("first inst_req", {31'b0, inst_req}, 32'h1);
        chk("first inst_addr", inst_addr, 32'hBFC0_0000);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("cap0 out_pc", out_pc, 32'hBFC0_0000);
        chk("cap0 out_inst", out_inst, 32'h2408_0001);
        chk("cap0 next addr", inst_addr, 32'hBFC0_0004);

        // decode stall with a full buffer
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
        #1;
        chk("stall inst_req", {31'b0, inst_req}, 32'h0);
        chk("stall out_pc", out_pc, 32'hBFC0_0000);
        chk("stall out_inst", out_inst, 32'h2408_0001);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("unstall issued pc", pc_f, 32'hBFC0_0004);
        chk("unstall out_valid", {31'b0, out_valid}, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("cap1 out_pc", out_pc, 32'hBFC0_0004);
        chk("cap1 out_inst", out_inst, 32'h2408_0005);

        // redirect during WAIT; stale response arrives 3 cycles later
        mem_lat = 4; mem_bad_next = 1'b1;
        cyc(1'b1, 1'b0, 32'h0);
        mem_lat = 1;
        cyc(1'b1, 1'b1, 32'h8000_0180);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("stale out_valid", {31'b0, out_valid}, 32'h0);
        chk("stale out_inst", out_inst, 32'h2408_0005);
        chk("redir inst_addr", inst_addr, 32'h8000_0180);
        chk("redir inst_req", {31'b0, inst_req}, 32'h1);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("cap2 out_pc", out_pc, 32'h8000_0180);
        chk("cap2 out_inst", out_inst, 32'h1BC8_0181);

        // redirect coinciding with addr_ok in REQ
        cyc(1'b1, 1'b1, 32'h8000_0180);
        #1;
        chk("rq redir out_valid", {31'b0, out_valid}, 32'h0);
        chk("rq redir inst_req", {31'b0, inst_req}, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("rq drop out_valid", {31'b0, out_valid}, 32'h0);
        chk("rq drop inst_addr", inst_addr, 32'h8000_0180);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("cap3 out_valid", {31'b0, out_valid}, 32'h1);
        chk("cap3 out_pc", out_pc, 32'h8000_0180);

        // asynchronous reset in the middle of WAIT
        cyc(1'b1, 1'b0, 32'h0);
        #3;
        resetn = 1'b0;
        model_reset();
        mem_cnt = 0;
        #1;
        chk("areset out_valid", {31'b0, out_valid}, 32'h0);
        chk("areset out_pc", out_pc, 32'h0);
        chk("areset out_inst", out_inst, 32'h0);
        chk("areset pc_f", pc_f, RST_PC);
        chk("areset inst_req", {31'b0, inst_req}, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1 resetn = 1'b1;
        #1;
        chk("restart inst_addr", inst_addr, 32'hBFC0_0000);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("restart out_inst", out_inst, 32'h2408_0001);

        // throughput: one instruction per two cycles
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("tput out_pc", out_pc, 32'hBFC0_0008);
        chk("tput out_inst", out_inst, 32'h2408_0009);

        // pcplus4 wraps at the top of the address space
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
        #1;
        chk("wrap pc_f", pc_f, 32'hFFFF_FFFC);
        chk("wrap pcplus4", pcplus4, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("wrap out_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap out_inst", out_inst, 32'h6437_FFFD);
        chk("wrap next pc", pc_f, 32'h0);

        // misaligned redirect target
        cyc(1'b1, 1'b1, 32'h8000_0002);
        cyc(1'b1, 1'b0, 32'h0);
`ifdef FETCH_ADDR_ALIGN_CHK_EN
        #1;
        chk("mis inst_req", {31'b0, inst_req}, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("mis out_valid", {31'b0, out_valid}, 32'h1);
        chk("mis out_exc", {31'b0, out_exc}, 32'h1);
        chk("mis out_pc", out_pc, 32'h8000_0002);
        chk("mis out_inst", out_inst, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h8000_0180);
        #1;
        chk("mis clr out_exc", {31'b0, out_exc}, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("mis recover out_pc", out_pc, 32'h8000_0180);
        chk("mis recover out_exc", {31'b0, out_exc}, 32'h0);
`else
        #1;
        chk("mis inst_req", {31'b0, inst_req}, 32'h1);
        chk("mis inst_addr", inst_addr, 32'h8000_0002);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        chk("mis out_pc", out_pc, 32'h8000_0002);
        chk("mis out_inst", out_inst, 32'h1BC8_0003);
        chk("mis out_exc", {31'b0, out_exc}, 32'h0);
`endif
        cyc(1'b1, 1'b0, 32'h0);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
